mult16_seq: RTL
===============

MULT16_SEQ -- requirements
Module: mult16_seq

Interface
REQ-001 SHALL have parameter SKIP_ZERO, default 1, meaning: when 1, an accepted operand pair with either operand equal to zero bypasses the multiply steps.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  requester presents an operand pair.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port a  input  16  unsigned multiplicand.
REQ-007 SHALL have port b  input  16  unsigned multiplier.
REQ-008 SHALL have port out_valid  output  1  result is valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port result  output  32  unsigned product a*b.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL compute each 16x16 product through exactly one instance of the team's 8x8 unsigned carry-save multiplier (mult), reused across steps; no other multiplier logic.
REQ-013 SHALL implement FSM states IDLE, MUL, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; in_ready SHALL depend on state only, with no combinational path from in_valid.
REQ-015 SHALL accept the operands on a cycle t with in_valid&in_ready; on that edge it latches a and b, clears the 32-bit accumulator, sets step=0, and enters MUL.
REQ-016 SHALL, in MUL, perform one step per cycle with 2-bit step k, adding the mult output, zero-extended and shifted, into the accumulator: k0 a[7:0]*b[7:0]<<0; k1 a[15:8]*b[7:0]<<8; k2 a[7:0]*b[15:8]<<8; k3 a[15:8]*b[15:8]<<16.
REQ-017 SHALL enter DONE after step 3, so out_valid first rises at cycle t+5 (latency 5 cycles from accept edge).
REQ-018 SHALL use 32-bit modulo accumulation; the maximum product 0xFFFE0001 never overflows.
REQ-019 SHALL, when SKIP_ZERO=1 and a==0 or b==0 at accept, go IDLE->DONE with accumulator 0, giving out_valid at t+1; when SKIP_ZERO=0, zero operands take the full 4 steps.
REQ-020 SHALL hold out_valid=1 and result stable in DONE until out_valid&out_ready; on that edge it returns to IDLE, with in_ready=1 on the following cycle.
REQ-021 SHALL drive result from the accumulator, valid while out_valid=1; operand changes on a/b after the accept edge SHALL NOT affect the result.
REQ-022 SHALL ignore in_valid outside IDLE; no operand is lost or double-accepted.
REQ-023 SHALL ignore out_ready when out_valid=0.

Reset
REQ-024 SHALL, while reset=1 and asynchronously on assertion, force state=IDLE, step=0, accumulator=0, latched operands=0; outputs then SHALL be in_ready=1, out_valid=0, busy=0, result=0.
REQ-025 SHALL abandon any operation in MUL or DONE on reset with no result emitted; the first cycle after reset deassertion SHALL accept a new operand pair.

Verification
REQ-026 SHALL be verified with: a=3, b=5 accepted at t -> out_valid at t+5, result=15, busy=1 during t+1..t+5.
REQ-027 SHALL be verified with: a=0xFFFF, b=0xFFFF -> result=0xFFFE0001 at t+5; a=0x1234, b=0xABCD -> result=0x0C374FA4.
REQ-028 SHALL be verified with: out_ready=0 for 10 cycles after out_valid while a/b toggle randomly -> result constant, in_ready=0 throughout; out_ready=1 -> IDLE and in_ready=1 the next cycle.
REQ-029 SHALL be verified with: SKIP_ZERO=1, a=0, b=0x1234 -> result=0 at t+1; SKIP_ZERO=0 with the same operands -> result=0 at t+5.
REQ-030 SHALL be verified with: reset asserted during MUL step 2 -> out_valid=0, result=0 immediately; a=2, b=7 after deassertion -> result=14, 5 cycles after accept.
REQ-031 SHALL be verified with: in_valid held high and out_ready tied high over 4 random pairs -> every product correct, one accept every 6 cycles, no pair skipped.

Source files
------------

// File: rtl/mult16_seq.sv
// Sequential 16x16 unsigned multiplier: one shared 8x8 carry-save multiplier
// is stepped over the four byte cross-products, accumulating into 32 bits.

module mult (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);
    logic [15:0] s, c, pp, s_n;

    // Carry-save reduction of the eight partial products, one resolving add at the end.
    always_comb begin
        s   = '0;
        c   = '0;
        pp  = '0;
        s_n = '0;
        for (int i = 0; i < 8; i++) begin
            pp  = {8'b0, a_i & {8{b_i[i]}}} << i;
            s_n = s ^ c ^ pp;
            c   = ((s & c) | (s & pp) | (c & pp)) << 1;
            s   = s_n;
        end
        p_o = s + c;
    end
endmodule

module mult16_seq #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [31:0] acc_q, acc_d;
    logic [1:0]  step_q, step_d;

    logic [7:0]  m_a, m_b;
    logic [15:0] m_p;
    logic [31:0] term;
    logic        accept, zero_op;

    assign accept  = in_valid && (state_q == IDLE);
    assign zero_op = (a == 16'd0) || (b == 16'd0);

    mult u_mult (
        .a_i (m_a),
        .b_i (m_b),
        .p_o (m_p)
    );

    // Byte select and weight for the current step.
    always_comb begin
        m_a  = a_q[7:0];
        m_b  = b_q[7:0];
        term = {16'b0, m_p};
        case (step_q)
            2'd1: begin
                m_a  = a_q[15:8];
                term = {8'b0, m_p, 8'b0};
            end
            2'd2: begin
                m_b  = b_q[15:8];
                term = {8'b0, m_p, 8'b0};
            end
            2'd3: begin
                m_a  = a_q[15:8];
                m_b  = b_q[15:8];
                term = {m_p, 16'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (SKIP_ZERO && zero_op) ? DONE : MUL;
            MUL:  if (step_q == 2'd3) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        step_d = step_q;
        if (accept) begin
            a_d    = a;
            b_d    = b;
            acc_d  = '0;
            step_d = '0;
        end else if (state_q == MUL) begin
            acc_d  = acc_q + term;
            step_d = step_q + 2'd1;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        result    = acc_q;
    end
endmodule
